// File: rtl/seq_int_divider.sv
// Multi-cycle radix-2 restoring integer divider with stb/ack operand and result handshakes.
// Produces quotient, remainder and a divide-by-zero flag; signed or unsigned by parameter.
module seq_int_divider #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_z,
  output logic [WIDTH-1:0] output_r,
  output logic             output_dbz,
  output logic             output_z_stb,
  input  logic             output_z_ack
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    PREP   = 3'd2,
    DIVIDE = 3'd3,
    FIXUP  = 3'd4,
    PUT_Z  = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_reg, a_reg_n;
  logic [WIDTH-1:0] divisor, divisor_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [CW-1:0]    count, count_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             a_ack_n, b_ack_n, z_stb_n, dbz_n;
  logic [WIDTH-1:0] z_n, r_n;
  logic [WIDTH:0]   trial;

  // Magnitude of an operand; the most negative value maps to its unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if (SIGNED && x[WIDTH-1]) begin
      magnitude = WIDTH'(~x + WIDTH'(1));
    end else begin
      magnitude = x;
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      a_reg        <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      count        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_dbz   <= 1'b0;
      output_z     <= '0;
      output_r     <= '0;
    end else begin
      state        <= state_n;
      a_reg        <= a_reg_n;
      divisor      <= divisor_n;
      rem          <= rem_n;
      quo          <= quo_n;
      count        <= count_n;
      neg_q        <= neg_q_n;
      neg_r        <= neg_r_n;
      input_a_ack  <= a_ack_n;
      input_b_ack  <= b_ack_n;
      output_z_stb <= z_stb_n;
      output_dbz   <= dbz_n;
      output_z     <= z_n;
      output_r     <= r_n;
    end
  end

  always_comb begin
    state_n   = state;
    a_reg_n   = a_reg;
    divisor_n = divisor;
    rem_n     = rem;
    quo_n     = quo;
    count_n   = count;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    a_ack_n   = input_a_ack;
    b_ack_n   = input_b_ack;
    z_stb_n   = output_z_stb;
    dbz_n     = output_dbz;
    z_n       = output_z;
    r_n       = output_r;
    // Shifted partial remainder minus divisor; the top bit is the borrow.
    trial     = {rem, quo[WIDTH-1]} - {1'b0, divisor};

    unique case (state)
      GET_A: begin
        if (input_a_ack && input_a_stb) begin
          a_reg_n = input_a;
          a_ack_n = 1'b0;
          b_ack_n = 1'b1;
          state_n = GET_B;
        end else begin
          a_ack_n = 1'b1;
        end
      end
      GET_B: begin
        if (input_b_ack && input_b_stb) begin
          divisor_n = input_b;
          b_ack_n   = 1'b0;
          state_n   = PREP;
        end else begin
          b_ack_n = 1'b1;
        end
      end
      PREP: begin
        neg_q_n   = SIGNED & (a_reg[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_n   = SIGNED & a_reg[WIDTH-1];
        quo_n     = magnitude(a_reg);
        divisor_n = magnitude(divisor);
        rem_n     = '0;
        count_n   = CW'(WIDTH);
        if (divisor == '0) begin
          z_n     = '1;
          r_n     = a_reg;
          dbz_n   = 1'b1;
          z_stb_n = 1'b1;
          state_n = PUT_Z;
        end else begin
          dbz_n   = 1'b0;
          state_n = DIVIDE;
        end
      end
      DIVIDE: begin
        if (!trial[WIDTH]) begin
          rem_n = trial[WIDTH-1:0];
        end else begin
          rem_n = {rem[WIDTH-2:0], quo[WIDTH-1]};
        end
        quo_n   = {quo[WIDTH-2:0], ~trial[WIDTH]};
        count_n = count - CW'(1);
        if (count == CW'(1)) begin
          state_n = FIXUP;
        end
      end
      FIXUP: begin
        z_n     = neg_q ? WIDTH'(~quo + WIDTH'(1)) : quo;
        r_n     = neg_r ? WIDTH'(~rem + WIDTH'(1)) : rem;
        z_stb_n = 1'b1;
        state_n = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_stb && output_z_ack) begin
          z_stb_n = 1'b0;
          state_n = GET_A;
        end
      end
      default: begin
        state_n = GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_int_divider.sv
// Bench for seq_int_divider: four instances (32/8 bit, unsigned/signed) driven by
// directed vectors, handshake and reset sequences, and a reference-model random sweep.
module tb_seq_int_divider;

  logic        clk;
  logic        rst;
  logic [31:0] a_in [4];
  logic [31:0] b_in [4];
  logic [3:0]  a_stb, b_stb, z_ack;
  logic [3:0]  a_ack, b_ack, z_stb, dbz;
  logic [31:0] z0, z1, r0, r1;
  logic [7:0]  z2, z3, r2, r3;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_int_divider #(.WIDTH(32), .SIGNED(1'b0)) u_w32u (
    .clk(clk), .rst(rst),
    .input_a(a_in[0]), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
    .input_b(b_in[0]), .input_b_stb(b_stb[0]), .input_b_ack(b_ack[0]),
    .output_z(z0), .output_r(r0), .output_dbz(dbz[0]),
    .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0]));

  seq_int_divider #(.WIDTH(32), .SIGNED(1'b1)) u_w32s (
    .clk(clk), .rst(rst),
    .input_a(a_in[1]), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
    .input_b(b_in[1]), .input_b_stb(b_stb[1]), .input_b_ack(b_ack[1]),
    .output_z(z1), .output_r(r1), .output_dbz(dbz[1]),
    .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1]));

  seq_int_divider #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .rst(rst),
    .input_a(a_in[2][7:0]), .input_a_stb(a_stb[2]), .input_a_ack(a_ack[2]),
    .input_b(b_in[2][7:0]), .input_b_stb(b_stb[2]), .input_b_ack(b_ack[2]),
    .output_z(z2), .output_r(r2), .output_dbz(dbz[2]),
    .output_z_stb(z_stb[2]), .output_z_ack(z_ack[2]));

  seq_int_divider #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .rst(rst),
    .input_a(a_in[3][7:0]), .input_a_stb(a_stb[3]), .input_a_ack(a_ack[3]),
    .input_b(b_in[3][7:0]), .input_b_stb(b_stb[3]), .input_b_ack(b_ack[3]),
    .output_z(z3), .output_r(r3), .output_dbz(dbz[3]),
    .output_z_stb(z_stb[3]), .output_z_ack(z_ack[3]));

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [31:0] r;
    logic        dbz;
    string       name;
  } vec_t;

  function automatic logic [31:0] get_z(input int sel);
    case (sel)
      0:       get_z = z0;
      1:       get_z = z1;
      2:       get_z = {24'h0, z2};
      default: get_z = {24'h0, z3};
    endcase
  endfunction

  function automatic logic [31:0] get_r(input int sel);
    case (sel)
      0:       get_r = r0;
      1:       get_r = r1;
      2:       get_r = {24'h0, r2};
      default: get_r = {24'h0, r3};
    endcase
  endfunction

  function automatic int width_of(input int sel);
    width_of = (sel < 2) ? 32 : 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference division using native integer arithmetic.
  task automatic ref_div(input int sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] z, output logic [31:0] r, output logic d);
    int w;
    longint mask, sa, sb, q, m;
    w    = width_of(sel);
    mask = (longint'(1) <<< w) - 1;
    if (b == 32'h0) begin
      z = 32'(mask);
      r = a;
      d = 1'b1;
    end else if (sel == 0 || sel == 2) begin
      z = a / b;
      r = a % b;
      d = 1'b0;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
      q  = sa / sb;
      m  = sa % sb;
      z  = 32'(q & mask);
      r  = 32'(m & mask);
      d  = 1'b0;
    end
  endtask

  // Hands a then b to one instance; returns 1 ns after the edge that accepts b.
  task automatic send_ab(input int sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    a_in[sel]  = a;
    a_stb[sel] = 1'b1;
    n = 0;
    while (!a_ack[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_ack wait", 32'(a_ack[sel]), 32'd1);
    @(negedge clk);
    a_stb[sel] = 1'b0;
    b_in[sel]  = b;
    b_stb[sel] = 1'b1;
    n = 0;
    while (!b_ack[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_ack wait", 32'(b_ack[sel]), 32'd1);
    @(posedge clk);
    #1 b_stb[sel] = 1'b0;
  endtask

  // Counts edges from b acceptance until the result strobe rises.
  task automatic wait_result(input int sel, input int exp_lat, input string name);
    int cnt;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (z_stb[sel]) break;
    end
    chk({name, " latency"}, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic check_out(input int sel, input logic [31:0] z, input logic [31:0] r,
                           input logic d, input string name);
    chk({name, " z"}, get_z(sel), z);
    chk({name, " r"}, get_r(sel), r);
    chk({name, " dbz"}, 32'(dbz[sel]), 32'(d));
  endtask

  task automatic ack_result(input int sel, input string name);
    if (!z_ack[sel]) begin
      @(negedge clk);
      z_ack[sel] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({name, " stb drop"}, 32'(z_stb[sel]), 32'd0);
    z_ack[sel] = 1'b0;
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input logic [31:0] r, input logic d,
                        input bit early, input string name);
    if (early) z_ack[sel] = 1'b1;
    send_ab(sel, a, b);
    wait_result(sel, d ? 1 : width_of(sel) + 2, name);
    check_out(sel, z, r, d, name);
    ack_result(sel, name);
  endtask

  vec_t vecs [11];

  initial begin
    logic [31:0] ra, rb, ez, er, mask;
    logic        ed;
    vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "u32 100/7"};
    vecs[1]  = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, "s32 -7/2"};
    vecs[2]  = '{0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, "u32 5/0"};
    vecs[3]  = '{1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, "s32 5/0"};
    vecs[4]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, "s32 min/-1"};
    vecs[5]  = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, "u32 big/max"};
    vecs[6]  = '{1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, "s32 100/-7"};
    vecs[7]  = '{2, 32'd200,        32'd9,          32'h16,         32'd2,          1'b0, "u8 200/9"};
    vecs[8]  = '{3, 32'h80,         32'hFF,         32'h80,         32'd0,          1'b0, "s8 min/-1"};
    vecs[9]  = '{3, 32'h85,         32'd10,         32'hF4,         32'hFD,         1'b0, "s8 -123/10"};
    vecs[10] = '{2, 32'd7,          32'd0,          32'hFF,         32'd7,          1'b1, "u8 7/0"};

    rst   = 1'b0;
    a_stb = '0;
    b_stb = '0;
    z_ack = '0;
    for (int i = 0; i < 4; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset a_ack", 32'(a_ack[i]), 32'd0);
      chk("reset z_stb", 32'(z_stb[i]), 32'd0);
    end
    chk("reset z", get_z(1), 32'd0);
    chk("reset r", get_r(1), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first a_ack", {28'h0, a_ack}, 32'hF);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].r, vecs[i].dbz,
             (i % 3) == 1, vecs[i].name);
    end

    // Result held under back-pressure, then released.
    send_ab(0, 32'd100, 32'd7);
    wait_result(0, 34, "hold");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold z", z0, 32'd14);
      chk("hold r", r0, 32'd2);
      chk("hold stb", 32'(z_stb[0]), 32'd1);
      chk("hold a_ack", 32'(a_ack[0]), 32'd0);
    end
    ack_result(0, "hold");
    chk("post ack a_ack", 32'(a_ack[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("post ack a_ack next", 32'(a_ack[0]), 32'd1);

    // Both operand strobes raised together.
    @(negedge clk);
    a_in[1]  = 32'hFFFFFFF9;
    b_in[1]  = 32'd2;
    a_stb[1] = 1'b1;
    b_stb[1] = 1'b1;
    for (int n = 0; n < 100 && !a_ack[1]; n++) @(negedge clk);
    chk("both b_ack pre", 32'(b_ack[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("both a taken", 32'(a_ack[1]), 32'd0);
    chk("both b_ack up", 32'(b_ack[1]), 32'd1);
    a_stb[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("both b taken", 32'(b_ack[1]), 32'd0);
    b_stb[1] = 1'b0;
    wait_result(1, 34, "both");
    check_out(1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "both");
    ack_result(1, "both");

    // Reset in the middle of a division.
    send_ab(0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst a_ack", 32'(a_ack[0]), 32'd0);
    chk("midrst b_ack", 32'(b_ack[0]), 32'd0);
    chk("midrst z_stb", 32'(z_stb[0]), 32'd0);
    chk("midrst z", z0, 32'd0);
    chk("midrst r", r0, 32'd0);
    chk("midrst dbz", 32'(dbz[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst a_ack after", 32'(a_ack[0]), 32'd1);
    run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "after rst");

    // Random sweep against the reference model.
    for (int sel = 0; sel < 4; sel++) begin
      mask = (width_of(sel) == 32) ? 32'hFFFFFFFF : 32'hFF;
      for (int i = 0; i < 100; i++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        if (i % 3 == 0)  rb = rb & 32'hF;
        if (i % 13 == 0) ra = (mask >> 1) + 32'd1;
        if (i % 26 == 0) rb = mask;
        if (i % 11 == 0) rb = 32'd0;
        ref_div(sel, ra, rb, ez, er, ed);
        run_op(sel, ra, rb, ez, er, ed, (i % 2) == 1, $sformatf("rand%0d_%0d", sel, i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_int_divider.md
Name: seq_int_divider

Overview:
- Parametrised multi-cycle integer divider: quotient, remainder and divide-by-zero flag.
- Generalised successor to the fixed 32-bit float divider: configurable width, signed/unsigned mode, remainder output, explicit divide-by-zero result.
- Uses the same stb/ack handshake as the existing arithmetic cores, so it drops into the same benches and datapaths.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32: operand/result width in bits, range 4..64.
- SIGNED, 1: 1 = two's-complement operands/results; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- input_a  in  WIDTH  dividend.
- input_a_stb  in  1  dividend valid.
- input_a_ack  out  1  dividend accepted.
- input_b  in  WIDTH  divisor.
- input_b_stb  in  1  divisor valid.
- input_b_ack  out  1  divisor accepted.
- output_z  out  WIDTH  quotient.
- output_r  out  WIDTH  remainder.
- output_dbz  out  1  divide-by-zero flag, valid with output_z_stb.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  result consumed.

Behaviour:
- Reset (rst=0, async):
  - State = GET_A.
  - All ack/stb outputs = 0.
  - output_z, output_r, output_dbz = 0; internal regs cleared.
  - Reset mid-operation aborts it; nothing is retained.
  - First edge after release: input_a_ack = 1.
- States: GET_A -> GET_B -> PREP -> DIVIDE -> FIXUP -> PUT_Z -> GET_A.
- GET_A:
  - input_a_ack = 1.
  - On an edge with input_a_stb & input_a_ack: latch input_a, ack = 0, go to GET_B.
- GET_B:
  - input_b_ack = 1.
  - On an edge with input_b_stb & input_b_ack: latch input_b, ack = 0, go to PREP.
  - Operands are always taken strictly in order a then b, even if both stb are high at once. A second operand cannot be accepted in the same cycle as the first.
- PREP (1 cycle):
  - SIGNED = 1: take magnitudes |a|, |b|; neg_q = sign(a) xor sign(b); neg_r = sign(a).
  - SIGNED = 0: neg_q = neg_r = 0.
  - Load partial remainder = 0, counter = WIDTH.
  - If b == 0: go directly to PUT_Z with output_z = all ones, output_r = a (original bits), output_dbz = 1, for both modes.
  - Otherwise go to DIVIDE with output_dbz = 0.
- DIVIDE (WIDTH cycles):
  - Each cycle: shift {rem, dividend} left by 1; trial-subtract |b| from rem using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and set the quotient LSB to 1; else restore and set LSB to 0.
  - Decrement counter; go to FIXUP when it reaches 0.
- FIXUP (1 cycle):
  - Quotient is negated (two's complement) if neg_q; remainder is negated if neg_r.
  - Register into output_z / output_r; go to PUT_Z.
- Signed overflow (SIGNED = 1, min / -1): z = min (wraps), r = 0, dbz = 0. No exception.
- PUT_Z:
  - output_z_stb = 1; output_z, output_r, output_dbz held stable.
  - On an edge with output_z_stb & output_z_ack: stb = 0, go to GET_A.
  - Outputs keep their last values after the handshake.
- Latency, counted from the edge that accepts b to the edge that raises output_z_stb:
  - Normal: WIDTH + 2 edges.
  - Divide by zero: 1 edge.
- Back-pressure:
  - output_z_ack may be held low indefinitely; the result stays frozen and no new operand is acked.
  - output_z_ack already high on stb assertion completes the handshake in one cycle.
- Identities: remainder magnitude < |b|; a == z*b + r (mod 2^WIDTH) for every non-dbz case.

Test Plan:
- WIDTH=32, SIGNED=0: a=100, b=7 -> z=14, r=2, dbz=0; z_stb rises exactly 34 edges after b is accepted.
- WIDTH=32, SIGNED=1: a=0xFFFFFFF9 (-7), b=2 -> z=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
- Divide by zero: a=5, b=0, both modes -> z=0xFFFFFFFF, r=5, dbz=1; z_stb rises 1 edge after b is accepted.
- Overflow: a=0x80000000, b=0xFFFFFFFF.
  - SIGNED=1 -> z=0x80000000, r=0.
  - SIGNED=0 -> z=0, r=0x80000000.
- Handshake:
  - Hold output_z_ack low 20 cycles -> z, r, stb stable and input_a_ack stays 0.
  - Raise ack -> stb drops next edge; input_a_ack = 1 on the following edge.
  - a_stb and b_stb high together -> accepted on consecutive edges.
- Reset and sweep:
  - Assert rst low mid-DIVIDE -> all outputs 0 immediately.
  - After release, input_a_ack = 1 and a fresh 100/7 completes correctly.
  - Run 100 random pairs at WIDTH=8 and WIDTH=32, both modes, against a reference model.
